// File: rtl/level_menu_select.sv
// ============================================================================
// Module      : level_menu_select
// Description : Menu-screen level chooser and unlock tracker feeding the level
//               manager. Optional idle auto-confirm under MENU_AUTOSTART_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module level_menu_select #(
   parameter int NUM_LEVELS     = 4,
   parameter int START_UNLOCKED = 0,
   parameter int AUTOSTART_SEC  = 10
) (
   input  logic       clk,
   input  logic       resetN,
   input  logic       menu_screen,
   input  logic       key_up,
   input  logic       key_down,
   input  logic       key_enter,
   input  logic       one_sec,
   input  logic       level_comp,
   output logic [1:0] lvl_selected,
   output logic       menu_comp,
   output logic [1:0] cursor,
   output logic [1:0] max_unlocked
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ARM    = 2'd1;
   localparam logic [1:0] ST_BROWSE = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;

   localparam logic [1:0] TOP_LEVEL   = 2'(NUM_LEVELS - 1);
   localparam logic [1:0] RESET_UNLCK = 2'(START_UNLOCKED);

   logic [1:0] state;
   logic       up_prev;
   logic       down_prev;
   logic       enter_prev;
   logic       up_edge;
   logic       down_edge;
   logic       enter_edge;
   logic       any_edge;
   logic       keys_idle;
   logic       auto_fire;

   assign up_edge    = key_up    & ~up_prev;
   assign down_edge  = key_down  & ~down_prev;
   assign enter_edge = key_enter & ~enter_prev;
   assign any_edge   = up_edge | down_edge | enter_edge;
   assign keys_idle  = ~(key_up | key_down | key_enter);

`ifdef MENU_AUTOSTART_EN
   localparam logic [3:0] AUTO_LAST = 4'(AUTOSTART_SEC - 1);

   logic [3:0] idle_sec;

   // Fires on the strobe that brings the idle count up to the threshold.
   assign auto_fire = one_sec & ~any_edge & (idle_sec == AUTO_LAST);

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         idle_sec <= 4'd0;
      end else if (state != ST_BROWSE || any_edge) begin
         idle_sec <= 4'd0;
      end else if (one_sec && idle_sec != 4'hF) begin
         idle_sec <= idle_sec + 4'd1;
      end
   end
`else
   logic unused_one_sec;
   assign unused_one_sec = one_sec;
   assign auto_fire      = 1'b0;
`endif

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state        <= ST_ARM;
         cursor       <= 2'd0;
         lvl_selected <= 2'd0;
         menu_comp    <= 1'b0;
         max_unlocked <= RESET_UNLCK;
         up_prev      <= 1'b0;
         down_prev    <= 1'b0;
         enter_prev   <= 1'b0;
      end else begin
         up_prev    <= key_up;
         down_prev  <= key_down;
         enter_prev <= key_enter;
         menu_comp  <= 1'b0;

         if (level_comp && lvl_selected == max_unlocked && max_unlocked != TOP_LEVEL) begin
            max_unlocked <= max_unlocked + 2'd1;
         end

         case (state)
            ST_IDLE: begin
               if (menu_screen) begin
                  cursor <= lvl_selected;
                  state  <= ST_ARM;
               end
            end
            // Keys still held from gameplay must be released before browsing.
            ST_ARM: begin
               if (!menu_screen) begin
                  state <= ST_IDLE;
               end else if (keys_idle) begin
                  state <= ST_BROWSE;
               end
            end
            ST_BROWSE: begin
               if (!menu_screen) begin
                  state <= ST_IDLE;
               end else if (enter_edge || auto_fire) begin
                  lvl_selected <= cursor;
                  menu_comp    <= 1'b1;
                  state        <= ST_DONE;
               end else if (up_edge && down_edge) begin
                  cursor <= cursor;
               end else if (up_edge) begin
                  cursor <= (cursor == max_unlocked) ? 2'd0 : cursor + 2'd1;
               end else if (down_edge) begin
                  cursor <= (cursor == 2'd0) ? max_unlocked : cursor - 2'd1;
               end
            end
            ST_DONE: begin
               if (!menu_screen) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire
